// File: rtl/shift_rotate_seq.sv
`default_nettype none
// ============================================================================
// Module   : shift_rotate_seq
// Purpose  : Iterative SHL/SHR/SHRA/ROL/ROR unit with a one-cycle done pulse.
//            Define FAST_SHIFT_EN to move up to 4 positions per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module shift_rotate_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R
);
    localparam int         c_CNT_W    = 5;
    localparam logic [2:0] c_OP_SHL   = 3'd0;
    localparam logic [2:0] c_OP_SHR   = 3'd1;
    localparam logic [2:0] c_OP_SHRA  = 3'd2;
    localparam logic [2:0] c_OP_ROL   = 3'd3;
    localparam logic [2:0] c_OP_ROR   = 3'd4;
    localparam logic [2:0] c_OP_PASS0 = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_work, w_work_nxt, w_work_step;
    logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_step;
    logic [2:0]         r_opq, w_opq_nxt;
    logic               w_last_step;
    logic               w_unused_b;

    // Shift amounts are taken mod 32, so the upper operand bits never matter.
    assign w_unused_b = ^B[WIDTH-1:c_CNT_W];

    function automatic logic [WIDTH-1:0] f_step1(input logic [WIDTH-1:0] v,
                                                 input logic [2:0]       o);
        case (o)
            c_OP_SHL:  f_step1 = {v[WIDTH-2:0], 1'b0};
            c_OP_SHR:  f_step1 = {1'b0, v[WIDTH-1:1]};
            c_OP_SHRA: f_step1 = {v[WIDTH-1], v[WIDTH-1:1]};
            c_OP_ROL:  f_step1 = {v[WIDTH-2:0], v[WIDTH-1]};
            c_OP_ROR:  f_step1 = {v[0], v[WIDTH-1:1]};
            default:   f_step1 = v;
        endcase
    endfunction

`ifdef FAST_SHIFT_EN
    logic [WIDTH-1:0] w_stage [0:4];
    logic [2:0]       w_amt;

    assign w_amt      = (r_cnt > 5'd4) ? 3'd4 : r_cnt[2:0];
    assign w_stage[0] = r_work;

    for (genvar gi = 0; gi < 4; gi++) begin : g_stage
        assign w_stage[gi+1] = f_step1(w_stage[gi], r_opq);
    end

    always_comb begin
        w_work_step = w_stage[4];
        case (w_amt)
            3'd0:    w_work_step = w_stage[0];
            3'd1:    w_work_step = w_stage[1];
            3'd2:    w_work_step = w_stage[2];
            3'd3:    w_work_step = w_stage[3];
            default: w_work_step = w_stage[4];
        endcase
    end

    assign w_cnt_step  = r_cnt - {2'b00, w_amt};
    assign w_last_step = (r_cnt <= 5'd4);
`else
    assign w_work_step = f_step1(r_work, r_opq);
    assign w_cnt_step  = r_cnt - 5'd1;
    assign w_last_step = (r_cnt == 5'd1);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_work_nxt  = r_work;
        w_cnt_nxt   = r_cnt;
        w_opq_nxt   = r_opq;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_work_nxt  = A;
                    w_opq_nxt   = op;
                    w_cnt_nxt   = B[c_CNT_W-1:0];
                    // Zero distance or a PASS code needs no shifting at all.
                    w_state_nxt = ((B[c_CNT_W-1:0] == 5'd0) || (op >= c_OP_PASS0))
                                  ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_work_nxt = w_work_step;
                w_cnt_nxt  = w_cnt_step;
                if (w_last_step) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= S_IDLE;
            r_work  <= '0;
            r_cnt   <= '0;
            r_opq   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            r_cnt   <= w_cnt_nxt;
            r_opq   <= w_opq_nxt;
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign R    = r_work;

endmodule
`default_nettype wire

// File: tb/tb_shift_rotate_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_rotate_seq
// Purpose  : Directed self-checking bench for shift_rotate_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shift_rotate_seq;
    logic        clk;
    logic        clr;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] R;

    int n_checks = 0;
    int n_fail   = 0;

    shift_rotate_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .clr   (clr),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .R     (R)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Expected latency (edges from the start-sampling edge to done) from the spec.
    function automatic int exp_lat(input logic [2:0] o, input logic [31:0] b);
        int m;
        m = int'(b[4:0]);
        if (m == 0 || o >= 3'd5) return 1;
`ifdef FAST_SHIFT_EN
        return (m + 3) / 4 + 1;
`else
        return m + 1;
`endif
    endfunction

    // Launch one op; optionally re-assert start (with other operands) while busy.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want, input int mid_at);
        int lat;
        int pulses;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        @(negedge clk);
        check({tag, "_busy1"}, {31'd0, busy}, 32'd1);
        while (!done && lat < 40) begin
            if (lat == mid_at) begin
                start = 1'b1; A = 32'hFFFF_FFFF; B = 32'd1;
            end
            @(posedge clk);
            lat++;
            #1 start = 1'b0;
            @(negedge clk);
        end
        check({tag, "_lat"}, lat, exp_lat(o, b));
        check({tag, "_R"}, R, want);
        @(negedge clk);
        check({tag, "_done_fall"}, {30'd0, busy, done}, 32'd0);
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check({tag, "_extra_done"}, pulses, 0);
        check({tag, "_R_hold"}, R, want);
    endtask

    initial begin
        int pulses;
        clr = 1'b0; start = 1'b0; op = 3'd0; A = '0; B = '0;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_R", R, 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;

        run_op("rol1",     3'd3, 32'h8000_0001, 32'd1,  32'h0000_0003, 0);
        run_op("shra4",    3'd2, 32'hF000_0000, 32'd4,  32'hFF00_0000, 0);
        run_op("shr4",     3'd1, 32'hF000_0000, 32'd4,  32'h0F00_0000, 0);
        run_op("ror33",    3'd4, 32'h0000_0001, 32'd33, 32'h8000_0000, 0);
        run_op("shl0",     3'd0, 32'h1234_5678, 32'd0,  32'h1234_5678, 0);
        run_op("pass",     3'd5, 32'hDEAD_BEEF, 32'd7,  32'hDEAD_BEEF, 0);
        run_op("ror4",     3'd4, 32'h1234_5678, 32'd4,  32'h8123_4567, 0);
        run_op("shra31",   3'd2, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 0);
        run_op("shl31",    3'd0, 32'h8000_0003, 32'd31, 32'h8000_0000, 0);
        run_op("rol_mid",  3'd3, 32'h1234_5678, 32'd8,  32'h3456_7812, 1);
        run_op("shr31",    3'd1, 32'hFFFF_FFFF, 32'd31, 32'h0000_0001, 0);

        // Asynchronous reset in the middle of a long shift.
        @(negedge clk);
        start = 1'b1; op = 3'd0; A = 32'd1; B = 32'd20;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("abort_busy_pre", {31'd0, busy}, 32'd1);
        clr = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_R", R, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        check("abort_no_resume", pulses, 0);
        run_op("shl20",    3'd0, 32'h0000_0001, 32'd20, 32'h0010_0000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
